// File: rtl/rans_csr_slave.sv
// rans_csr_slave: AXI4-Lite register bank fronting the rANS encoder core.
// Ports:
//   aclk/areset                   clock, synchronous active-high reset
//   aw*/w*/b*                     AXI4-Lite write address, data and response channels
//   ar*/r*                        AXI4-Lite read address and data channels
//   core_start                    one-cycle start pulse to the encoder
//   core_busy/done/out_len        encoder status inputs
//   cfg_src_addr/cfg_length       configuration register contents
// Register map (addr[4:2]): 0 CTRL, 1 STATUS, 2 SRC_ADDR, 3 LENGTH, 4 OUT_LEN, 5 ID, 6-7 SLVERR.
module rans_csr_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'h5241_4E53
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    core_start,
  input  logic                    core_busy,
  input  logic                    core_done,
  input  logic [DATA_WIDTH-1:0]   core_out_len,
  output logic [DATA_WIDTH-1:0]   cfg_src_addr,
  output logic [DATA_WIDTH-1:0]   cfg_length
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [2:0]            aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  core_start_q, core_start_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] src_addr_q, src_addr_d, length_q, length_d;
  logic                  w1c_c;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:5], awaddr[1:0],
                              araddr[ADDR_WIDTH-1:5], araddr[1:0]};

  // Byte-lane merge of write data into an existing register value
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_v,
                                                        input logic [DATA_WIDTH-1:0] new_v,
                                                        input logic [STRB_W-1:0]     strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Write channel: independent AW/W capture, commit once both slots are full
  always_comb begin
    wstate_d     = wstate_q;
    aw_full_d    = aw_full_q;
    aw_idx_d     = aw_idx_q;
    w_full_d     = w_full_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    core_start_d = 1'b0;
    src_addr_d   = src_addr_q;
    length_d     = length_q;
    w1c_c        = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          aw_full_d = 1'b1;
          aw_idx_d  = awaddr[4:2];
        end
        if (wvalid && wready_q) begin
          w_full_d = 1'b1;
          w_data_d = wdata;
          w_strb_d = wstrb;
        end
        if (aw_full_q && w_full_q) begin
          case (aw_idx_q)
            3'd0:    core_start_d = w_strb_q[0] && w_data_q[0] && !core_busy;
            3'd1:    w1c_c = w_strb_q[0] && w_data_q[1];
            3'd2:    src_addr_d = merge_lanes(src_addr_q, w_data_q, w_strb_q);
            3'd3:    length_d   = merge_lanes(length_q, w_data_q, w_strb_q);
            default: ;
          endcase
          bresp_d   = (aw_idx_q >= 3'd6) ? SLVERR : OKAY;
          bvalid_d  = 1'b1;
          wstate_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE) && !aw_full_d;
    wready_d  = (wstate_d == W_IDLE) && !w_full_d;
    // A done pulse coinciding with the clear keeps the flag set
    done_d    = core_done || (done_q && !w1c_c);
  end

  // Read channel: capture register value at AR handshake, hold until rready
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    case (rstate_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          rresp_d = OKAY;
          case (araddr[4:2])
            3'd1:    rdata_d = DATA_WIDTH'({done_q, core_busy});
            3'd2:    rdata_d = src_addr_q;
            3'd3:    rdata_d = length_q;
            3'd4:    rdata_d = core_out_len;
            3'd5:    rdata_d = DATA_WIDTH'(ID_VALUE);
            3'd6,
            3'd7: begin
              rdata_d = '0;
              rresp_d = SLVERR;
            end
            default: rdata_d = '0;
          endcase
          rvalid_d = 1'b1;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q     <= W_IDLE;
      rstate_q     <= R_IDLE;
      aw_full_q    <= 1'b0;
      aw_idx_q     <= '0;
      w_full_q     <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= OKAY;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rresp_q      <= OKAY;
      rdata_q      <= '0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      src_addr_q   <= '0;
      length_q     <= '0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      aw_full_q    <= aw_full_d;
      aw_idx_q     <= aw_idx_d;
      w_full_q     <= w_full_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
      src_addr_q   <= src_addr_d;
      length_q     <= length_d;
    end
  end

  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign arready      = arready_q;
  assign rvalid       = rvalid_q;
  assign rresp        = rresp_q;
  assign rdata        = rdata_q;
  assign core_start   = core_start_q;
  assign cfg_src_addr = src_addr_q;
  assign cfg_length   = length_q;

endmodule

// File: tb/tb_rans_csr_slave.sv
// Self-checking bench for rans_csr_slave against a register-map level model.
module tb_rans_csr_slave;

  localparam logic [31:0] ID = 32'h5241_4E53;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, wdata, araddr, rdata, core_out_len, cfg_src_addr, cfg_length;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        core_start, core_busy, core_done;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_src, m_len;
  bit          m_done;

  rans_csr_slave dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
    .core_out_len(core_out_len), .cfg_src_addr(cfg_src_addr), .cfg_length(cfg_length)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (strb[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    case (addr[4:2])
      3'd1:    return {30'h0, m_done, core_busy};
      3'd2:    return m_src;
      3'd3:    return m_len;
      3'd4:    return core_out_len;
      3'd5:    return ID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_src = 32'h0; m_len = 32'h0; m_done = 1'b0;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    m_done = 1'b1;
  endtask

  // Full write transaction; done_at_commit raises core_done on the commit cycle
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, input bit done_at_commit);
    int          cyc, n;
    bit          aw_done, w_done, aw_hs, w_hs, exp_start;
    logic [31:0] mask;
    logic [1:0]  exp_resp;
    cyc = 0; aw_done = 0; w_done = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 60) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      @(negedge aclk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_handshake", 32'(aw_done && w_done), 32'd1);
    exp_start = (addr[4:2] == 3'd0) && strb[0] && data[0] && !core_busy;
    exp_resp  = (addr[4:2] >= 3'd6) ? 2'b10 : 2'b00;
    mask = lane_mask(strb);
    case (addr[4:2])
      3'd1: if (strb[0] && data[1]) m_done = 1'b0;
      3'd2: m_src = (m_src & ~mask) | (data & mask);
      3'd3: m_len = (m_len & ~mask) | (data & mask);
      default: ;
    endcase
    if (done_at_commit) m_done = 1'b1;
    core_done = done_at_commit;
    n = 0;
    do begin
      step();
      core_done = 1'b0;
      n++;
    end while (!bvalid && n < 20);
    chk("b_latency", 32'(n), 32'd1);
    chk("bresp", 32'(bresp), 32'(exp_resp));
    chk("core_start_pulse", 32'(core_start), 32'(exp_start));
    for (int i = 0; i < b_dly; i++) begin
      step();
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("bresp_hold", 32'(bresp), 32'(exp_resp));
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bvalid_drop", 32'(bvalid), 32'd0);
    chk("core_start_width", 32'(core_start), 32'd0);
    chk("cfg_src_addr", cfg_src_addr, m_src);
    chk("cfg_length", cfg_length, m_len);
  endtask

  // Full read transaction with rready held low for hold cycles
  task automatic do_read(input logic [31:0] addr, input int hold);
    int          cyc;
    bit          hs;
    logic [31:0] exp;
    logic [1:0]  exp_resp;
    cyc = 0; hs = 0;
    araddr = addr; arvalid = 1'b1;
    exp = 32'h0;
    while (!hs && cyc < 40) begin
      @(negedge aclk);
      hs  = arvalid && arready;
      exp = model_rd(addr);
      step();
      cyc++;
    end
    arvalid = 1'b0;
    exp_resp = (addr[4:2] >= 3'd6) ? 2'b10 : 2'b00;
    chk("ar_handshake", 32'(hs), 32'd1);
    chk("rvalid", 32'(rvalid), 32'd1);
    chk("rdata", rdata, exp);
    chk("rresp", 32'(rresp), 32'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rdata_hold", rdata, exp);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a, d;
    areset = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    core_busy = 0; core_done = 0; core_out_len = 32'h0000_0123;
    model_reset();
    repeat (3) step();
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_src", cfg_src_addr, 32'h0);
    chk("rst_len", cfg_length, 32'h0);
    areset = 1'b0;

    // SRC_ADDR with AW two cycles ahead of W
    do_write(32'h08, 32'h0000_1000, 4'hF, 0, 2, 0, 0);
    chk("src_1000", cfg_src_addr, 32'h0000_1000);
    // Partial strobe on LENGTH
    do_write(32'h0C, 32'hAABB_CCDD, 4'b0101, 1, 0, 2, 0);
    chk("len_partial", cfg_length, 32'h00BB_00DD);
    do_read(32'h0C, 0);
    // START with and without busy
    do_write(32'h00, 32'h1, 4'h1, 0, 0, 0, 0);
    core_busy = 1'b1;
    do_write(32'h00, 32'h1, 4'h1, 0, 0, 0, 0);
    do_read(32'h04, 0);
    core_busy = 1'b0;
    // DONE sticky, set wins over simultaneous clear, then clear
    pulse_done();
    do_read(32'h04, 0);
    do_write(32'h04, 32'h2, 4'hF, 0, 0, 0, 1);
    do_read(32'h04, 0);
    do_write(32'h04, 32'h2, 4'hF, 0, 0, 0, 0);
    do_read(32'h04, 0);
    // Decode-error index, ID with backpressure, OUT_LEN, RO writes
    do_read(32'h18, 0);
    do_write(32'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, 1, 0);
    do_read(32'h14, 5);
    do_read(32'h10, 1);
    do_write(32'h14, 32'h1234_5678, 4'hF, 0, 0, 0, 0);
    do_read(32'h14, 0);
    do_read(32'h00, 0);

    // Randomized mix checked against the model
    for (int k = 0; k < 60; k++) begin
      a = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      d = $urandom;
      core_busy    = 1'($urandom_range(0, 1));
      core_out_len = $urandom;
      case ($urandom_range(0, 3))
        0, 1: do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        2:    do_read(a, $urandom_range(0, 3));
        default: pulse_done();
      endcase
    end
    core_busy = 1'b0;

    // Reset with a write response pending and a read in flight
    awaddr = 32'h08; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 10) begin step(); n++; end
    chk("pre_rst_bvalid", 32'(bvalid), 32'd1);
    araddr = 32'h14; arvalid = 1'b1;
    step();
    areset = 1'b1; arvalid = 1'b0;
    step();
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_src", cfg_src_addr, 32'h0);
    chk("mid_rst_len", cfg_length, 32'h0);
    areset = 1'b0;
    model_reset();
    step();
    chk("post_rst_bvalid", 32'(bvalid), 32'd0);
    do_write(32'h0C, 32'h0000_0040, 4'hF, 0, 1, 0, 0);
    do_read(32'h0C, 0);
    do_read(32'h04, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
